// File: rtl/ps2_mouse_tx.sv
// PS/2 mouse transmitter: captures button/movement state on a send request
// and serialises a three-byte mouse packet onto device-driven PS/2 lines.
module ps2_mouse_tx #(
  parameter int HALF_CYC = 2500,
  parameter int GAP_CYC  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic       Click,
  input  logic       Izquierda,
  input  logic       Derecha,
  input  logic       Arriba,
  input  logic       Abajo,
  input  logic [7:0] MagX,
  input  logic [7:0] MagY,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, BIT_HI, BIT_LO, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [1:0]    byteCnt_q, byteCnt_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [7:0]    byte2_q, byte2_d;
  logic          ps2Clk_q, ps2Clk_d;
  logic          ps2Data_q, ps2Data_d;

  logic [8:0]    moveX, moveY;
  logic [7:0]    curByte;

  // Signed 9-bit movement from a pair of opposing direction flags.
  // Negating a zero magnitude wraps back to zero, so -0 encodes as +0.
  function automatic logic [8:0] movement(input logic pos, input logic neg,
                                          input logic [7:0] mag);
    if (pos && !neg)      movement = {1'b0, mag};
    else if (neg && !pos) movement = 9'(~{1'b0, mag} + 9'd1);
    else                  movement = 9'd0;
  endfunction

  // Line level for frame position idx: start, 8 data LSB first, odd parity, stop.
  function automatic logic frameBit(input logic [7:0] data, input logic [3:0] idx);
    case (idx)
      4'd0:    frameBit = 1'b0;
      4'd9:    frameBit = ~^data;
      default: frameBit = (idx <= 4'd8) ? data[3'(idx - 4'd1)] : 1'b1;
    endcase
  endfunction

  assign moveX = movement(Derecha, Izquierda, MagX);
  assign moveY = movement(Arriba, Abajo, MagY);

  // Next-state logic: phase timer, bit/byte sequencing and packet snapshot.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    byte2_d   = byte2_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          byte0_d   = {2'b00, moveY[8], moveX[8], 1'b1, 2'b00, Click};
          byte1_d   = moveX[7:0];
          byte2_d   = moveY[7:0];
          bitCnt_d  = 4'd0;
          byteCnt_d = 2'd0;
          timer_d   = HALF_LOAD;
          state_d   = BIT_HI;
        end
      end
      BIT_HI: begin
        if (timer_q == '0) begin
          timer_d = HALF_LOAD;
          state_d = BIT_LO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      BIT_LO: begin
        if (timer_q == '0) begin
          if (bitCnt_q == 4'd10) begin
            bitCnt_d = 4'd0;
            if (byteCnt_q == 2'd2) begin
              timer_d = '0;
              state_d = DONE;
            end else begin
              byteCnt_d = byteCnt_q + 2'd1;
              timer_d   = GAP_LOAD;
              state_d   = GAP;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            timer_d  = HALF_LOAD;
            state_d  = BIT_HI;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          timer_d = HALF_LOAD;
          state_d = BIT_HI;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line drivers follow the next state so they are glitch-free registers.
  always_comb begin
    case (byteCnt_d)
      2'd0:    curByte = byte0_d;
      2'd1:    curByte = byte1_d;
      default: curByte = byte2_d;
    endcase
    ps2Clk_d  = (state_d != BIT_LO);
    ps2Data_d = 1'b1;
    if (state_d == BIT_HI || state_d == BIT_LO) begin
      ps2Data_d = frameBit(curByte, bitCnt_d);
    end
  end

  // State, counters, snapshot and line registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bitCnt_q  <= 4'd0;
      byteCnt_q <= 2'd0;
      byte0_q   <= 8'd0;
      byte1_q   <= 8'd0;
      byte2_q   <= 8'd0;
      ps2Clk_q  <= 1'b1;
      ps2Data_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      byte2_q   <= byte2_d;
      ps2Clk_q  <= ps2Clk_d;
      ps2Data_q <= ps2Data_d;
    end
  end

  assign ps2_clk  = ps2Clk_q;
  assign ps2_data = ps2Data_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Scoreboard bench for ps2_mouse_tx: stimulus pushes expected bytes and busy
// lengths; independent monitors decode the PS/2 lines and compare.
module tb_ps2_mouse_tx;

  localparam int HALF = 2;
  localparam int GAPC = 4;
  localparam int BUSY_LEN = 66 * HALF + 2 * GAPC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic       Click = 1'b0, Izquierda = 1'b0, Derecha = 1'b0, Arriba = 1'b0, Abajo = 1'b0;
  logic [7:0] MagX = 8'd0, MagY = 8'd0;
  logic       ps2_clk, ps2_data, busy, done;

  int compared = 0;
  int mismatched = 0;
  int donePulses = 0;

  logic [7:0] expBytes[$];
  int         expBusy[$];

  ps2_mouse_tx #(.HALF_CYC(HALF), .GAP_CYC(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .Click(Click),
    .Izquierda(Izquierda), .Derecha(Derecha), .Arriba(Arriba), .Abajo(Abajo),
    .MagX(MagX), .MagY(MagY), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .done(done)
  );

  // 100 MHz-style system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: samples ps2_data on each ps2_clk fall, checks full frames
  initial begin : frameMonitor
    logic [10:0] frame;
    int          bitIdx;
    logic        prevClk, lowData, unstable;
    logic [7:0]  exp;
    bitIdx = 0; prevClk = 1'b1; lowData = 1'b1; unstable = 1'b0; frame = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitIdx = 0; prevClk = 1'b1; unstable = 1'b0;
      end else begin
        if (prevClk && !ps2_clk) begin
          frame[bitIdx] = ps2_data;
          lowData = ps2_data;
          bitIdx++;
        end else if (!prevClk && !ps2_clk && ps2_data != lowData) begin
          unstable = 1'b1;
        end
        if (!prevClk && ps2_clk && bitIdx == 11) begin
          if (expBytes.size() == 0) begin
            checkOutput("unexpected_byte", int'(frame[8:1]), -1);
          end else begin
            exp = expBytes.pop_front();
            checkOutput("data_byte", int'(frame[8:1]), int'(exp));
            checkOutput("start_bit", int'(frame[0]), 0);
            checkOutput("parity_bit", int'(frame[9]), int'(~^exp));
            checkOutput("stop_bit", int'(frame[10]), 1);
            checkOutput("data_stable_low", int'(unstable), 0);
          end
          bitIdx = 0;
          unstable = 1'b0;
        end
        prevClk = ps2_clk;
      end
    end
  end

  // Busy/done monitor: measures each busy window and counts done pulses in it
  initial begin : busyMonitor
    int   busyCnt, doneCnt;
    logic prevBusy;
    busyCnt = 0; doneCnt = 0; prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busyCnt = 0; doneCnt = 0; prevBusy = 1'b0;
      end else begin
        if (busy) busyCnt++;
        if (done) begin
          doneCnt++;
          donePulses++;
          checkOutput("done_inside_busy", int'(busy), 1);
        end
        if (prevBusy && !busy) begin
          if (expBusy.size() == 0) begin
            checkOutput("unexpected_packet", busyCnt, -1);
          end else begin
            checkOutput("busy_cycles", busyCnt, expBusy.pop_front());
            checkOutput("done_per_packet", doneCnt, 1);
          end
          busyCnt = 0;
          doneCnt = 0;
        end
        prevBusy = busy;
      end
    end
  end

  // Load inputs, pulse send for one cycle and push the hand-computed bytes
  task automatic applyStimulus(input logic c, input logic iz, input logic de,
                               input logic ar, input logic ab,
                               input logic [7:0] mx, input logic [7:0] my,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2);
    @(negedge clk);
    Click = c; Izquierda = iz; Derecha = de; Arriba = ar; Abajo = ab;
    MagX = mx; MagY = my;
    send = 1'b1;
    expBytes.push_back(e0);
    expBytes.push_back(e1);
    expBytes.push_back(e2);
    expBusy.push_back(BUSY_LEN);
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitFalls(input int n);
    int   falls;
    logic prev;
    falls = 0;
    prev = ps2_clk;
    for (int i = 0; i < 400 && falls < n; i++) begin
      @(negedge clk);
      if (prev && !ps2_clk) falls++;
      prev = ps2_clk;
    end
    if (falls < n) checkOutput("fall_wait_timeout", falls, n);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #12;
    checkOutput("reset_ps2_clk", int'(ps2_clk), 1);
    checkOutput("reset_ps2_data", int'(ps2_data), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);

    // Directed packets: right+up, left+down with click, cancelling flags, -0, max
    applyStimulus(0, 0, 1, 1, 0, 8'd15,  8'd15,  8'h08, 8'h0F, 8'h0F); waitDone("pkt_ru");
    idleCycles(5);
    applyStimulus(1, 1, 0, 0, 1, 8'd15,  8'd15,  8'h39, 8'hF1, 8'hF1); waitDone("pkt_ld");
    idleCycles(5);
    applyStimulus(0, 1, 1, 1, 1, 8'd200, 8'd200, 8'h08, 8'h00, 8'h00); waitDone("pkt_both");
    idleCycles(5);
    applyStimulus(0, 1, 0, 0, 0, 8'd0,   8'd0,   8'h08, 8'h00, 8'h00); waitDone("pkt_neg0");
    idleCycles(5);
    applyStimulus(0, 0, 1, 0, 0, 8'd255, 8'd0,   8'h08, 8'hFF, 8'h00); waitDone("pkt_max");
    idleCycles(5);
    applyStimulus(0, 1, 0, 1, 0, 8'd1,   8'd128, 8'h18, 8'hFF, 8'h80); waitDone("pkt_m1");
    idleCycles(5);

    // Send and input changes during byte1 must not disturb the packet
    applyStimulus(0, 0, 1, 1, 0, 8'd15, 8'd15, 8'h08, 8'h0F, 8'h0F);
    waitFalls(13);
    @(negedge clk);
    MagX = 8'd99; Izquierda = 1'b1; Click = 1'b1;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    waitDone("pkt_ignore");
    idleCycles(60);
    checkOutput("no_second_packet_busy", int'(busy), 0);

    // send held through DONE starts a back-to-back packet
    @(negedge clk);
    Click = 1'b1; Izquierda = 1'b0; Derecha = 1'b1; Arriba = 1'b0; Abajo = 1'b1;
    MagX = 8'd3; MagY = 8'd2;
    repeat (2) begin
      expBytes.push_back(8'h29); expBytes.push_back(8'h03); expBytes.push_back(8'hFE);
      expBusy.push_back(BUSY_LEN);
    end
    send = 1'b1;
    waitDone("pkt_held_a");
    @(posedge clk);
    @(posedge clk);
    #1 send = 1'b0;
    waitDone("pkt_held_b");
    idleCycles(5);

    // Reset during byte1 bit4 low phase, then a full packet
    applyStimulus(1, 1, 0, 0, 1, 8'd15, 8'd15, 8'h39, 8'hF1, 8'hF1);
    waitFalls(16);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_ps2_clk", int'(ps2_clk), 1);
    checkOutput("midreset_ps2_data", int'(ps2_data), 1);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    expBytes.delete();
    expBusy.delete();
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);
    applyStimulus(0, 0, 1, 1, 0, 8'd15, 8'd15, 8'h08, 8'h0F, 8'h0F); waitDone("pkt_after_reset");
    idleCycles(60);

    checkOutput("leftover_bytes", expBytes.size(), 0);
    checkOutput("leftover_packets", expBusy.size(), 0);
    checkOutput("total_done_pulses", donePulses, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
